// File: rtl/ram_sched_pkg.sv
// Shared types and default geometry for the RAM write scheduler.
package ram_sched_pkg;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 3;

   typedef enum logic {REQ_USR, REQ_CLR} req_id_t;

endpackage

// File: rtl/ram_write_scheduler_scan_sequencer.sv
// Tick-paced read-port scanner.  Walks the RAM address space and captures
// each word once the registered RAM output has settled for the new address,
// or again after a write lands on the word currently being displayed.
module scan_sequencer #(
   parameter int ADDR_W   = ram_sched_pkg::ADDR_W,
   parameter int DATA_W   = ram_sched_pkg::DATA_W,
   parameter int TICK_DIV = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              scan_pause,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] rd_q,
   output logic [ADDR_W-1:0] scan_addr,
   output logic [DATA_W-1:0] scan_data,
   output logic              scan_valid
);

   localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

   logic [TICK_W-1:0] tick_q, tick_d;
   logic [ADDR_W-1:0] scan_addr_q, scan_addr_d;
   logic [1:0]        settle_q, settle_d;
   logic [DATA_W-1:0] scan_data_q, scan_data_d;
   logic              scan_valid_q, scan_valid_d;
   logic              advance;
   logic              write_hit;

   // Tick divider and scan address; both freeze while paused.
   always_comb begin
      tick_d      = tick_q;
      scan_addr_d = scan_addr_q;
      advance     = 1'b0;
      if (!scan_pause) begin
         if (tick_q == TICK_LAST) begin
            tick_d      = '0;
            scan_addr_d = scan_addr_q + 1'b1;
            advance     = 1'b1;
         end else begin
            tick_d = tick_q + 1'b1;
         end
      end
   end

   // Settle countdown: restart on address change or a write to the scanned
   // word, and capture the RAM output when the count reaches zero.
   always_comb begin
      write_hit    = wr_en && (wr_addr == scan_addr_q);
      settle_d     = settle_q;
      scan_data_d  = scan_data_q;
      scan_valid_d = scan_valid_q;
      if (advance || write_hit) begin
         settle_d     = 2'd2;
         scan_valid_d = 1'b0;
      end else if (settle_q != 2'd0) begin
         settle_d = settle_q - 2'd1;
         if (settle_q == 2'd1) begin
            scan_data_d  = rd_q;
            scan_valid_d = 1'b1;
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         tick_q       <= '0;
         scan_addr_q  <= '0;
         settle_q     <= 2'd2;
         scan_data_q  <= '0;
         scan_valid_q <= 1'b0;
      end else begin
         tick_q       <= tick_d;
         scan_addr_q  <= scan_addr_d;
         settle_q     <= settle_d;
         scan_data_q  <= scan_data_d;
         scan_valid_q <= scan_valid_d;
      end
   end

   assign scan_addr  = scan_addr_q;
   assign scan_data  = scan_data_q;
   assign scan_valid = scan_valid_q;

endmodule

// File: rtl/ram_write_scheduler.sv
// Schedules the 32x3 dual-port RAM: round-robin write-port arbitration
// between the user switch writer and the zero-fill clear engine, plus the
// read-port scanner feeding the HEX display path.
module ram_write_scheduler #(
   parameter int ADDR_W   = ram_sched_pkg::ADDR_W,
   parameter int DATA_W   = ram_sched_pkg::DATA_W,
   parameter int TICK_DIV = 50_000_000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              usr_req,
   input  logic [ADDR_W-1:0] usr_addr,
   input  logic [DATA_W-1:0] usr_data,
   output logic              usr_gnt,
   input  logic              clr_start,
   output logic              clr_busy,
   input  logic              scan_pause,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_q,
   output logic [ADDR_W-1:0] scan_addr,
   output logic [DATA_W-1:0] scan_data,
   output logic              scan_valid
);

   import ram_sched_pkg::*;

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic              usr_gnt_q, usr_gnt_d;
   logic              clr_busy_q, clr_busy_d;
   logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
   req_id_t           last_winner_q, last_winner_d;
   logic              usr_elig, clr_elig;
   logic              usr_win, clr_win;

   // Pick a winner among eligible requesters; ties go to whoever did not
   // win last.  The user is masked in its grant cycle to avoid a double write.
   always_comb begin
      usr_elig = usr_req && !usr_gnt_q;
      clr_elig = clr_busy_q;
      usr_win  = 1'b0;
      clr_win  = 1'b0;
      if (usr_elig && clr_elig) begin
         if (last_winner_q == REQ_USR) begin
            clr_win = 1'b1;
         end else begin
            usr_win = 1'b1;
         end
      end else if (usr_elig) begin
         usr_win = 1'b1;
      end else if (clr_elig) begin
         clr_win = 1'b1;
      end
   end

   // Register the winning write and advance the clear engine.
   always_comb begin
      wr_en_d       = usr_win || clr_win;
      usr_gnt_d     = usr_win;
      wr_addr_d     = wr_addr_q;
      wr_data_d     = wr_data_q;
      last_winner_d = last_winner_q;
      clr_busy_d    = clr_busy_q;
      clr_addr_d    = clr_addr_q;
      if (usr_win) begin
         wr_addr_d     = usr_addr;
         wr_data_d     = usr_data;
         last_winner_d = REQ_USR;
      end else if (clr_win) begin
         wr_addr_d     = clr_addr_q;
         wr_data_d     = '0;
         last_winner_d = REQ_CLR;
         clr_addr_d    = clr_addr_q + 1'b1;
         if (clr_addr_q == LAST_ADDR) begin
            clr_busy_d = 1'b0;
         end
      end
      if (!clr_busy_q && clr_start) begin
         clr_busy_d = 1'b1;
         clr_addr_d = '0;
      end
   end

   // Write-port and clear-engine registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_en_q       <= 1'b0;
         wr_addr_q     <= '0;
         wr_data_q     <= '0;
         usr_gnt_q     <= 1'b0;
         clr_busy_q    <= 1'b0;
         clr_addr_q    <= '0;
         last_winner_q <= REQ_CLR;
      end else begin
         wr_en_q       <= wr_en_d;
         wr_addr_q     <= wr_addr_d;
         wr_data_q     <= wr_data_d;
         usr_gnt_q     <= usr_gnt_d;
         clr_busy_q    <= clr_busy_d;
         clr_addr_q    <= clr_addr_d;
         last_winner_q <= last_winner_d;
      end
   end

   scan_sequencer #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .TICK_DIV (TICK_DIV)
   ) u_scan (
      .clk        (clk),
      .reset      (reset),
      .scan_pause (scan_pause),
      .wr_en      (wr_en_q),
      .wr_addr    (wr_addr_q),
      .rd_q       (rd_q),
      .scan_addr  (scan_addr),
      .scan_data  (scan_data),
      .scan_valid (scan_valid)
   );

   assign wr_en    = wr_en_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign usr_gnt  = usr_gnt_q;
   assign clr_busy = clr_busy_q;
   assign rd_addr  = scan_addr;

endmodule

// File: tb/tb_ram_write_scheduler.sv
// Bench for ram_write_scheduler with a behavioural registered-read RAM.
module tb_ram_write_scheduler;

   logic       clk;
   logic       reset;
   logic       usr_req;
   logic [4:0] usr_addr;
   logic [2:0] usr_data;
   logic       usr_gnt;
   logic       clr_start;
   logic       clr_busy;
   logic       scan_pause;
   logic       wr_en;
   logic [4:0] wr_addr;
   logic [2:0] wr_data;
   logic [4:0] rd_addr;
   logic [2:0] rd_q;
   logic [4:0] scan_addr;
   logic [2:0] scan_data;
   logic       scan_valid;
   logic       tb_init;

   logic [2:0] mem [32];

   int checks;
   int failures;

   typedef struct {
      logic       req;
      logic [4:0] addr;
      logic [2:0] data;
      logic       clr;
      logic       exp_en;
      logic [4:0] exp_addr;
      logic [2:0] exp_data;
      logic       exp_gnt;
      logic       exp_busy;
   } vec_t;

   vec_t vecs [10];

   ram_write_scheduler #(
      .ADDR_W   (5),
      .DATA_W   (3),
      .TICK_DIV (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .usr_req    (usr_req),
      .usr_addr   (usr_addr),
      .usr_data   (usr_data),
      .usr_gnt    (usr_gnt),
      .clr_start  (clr_start),
      .clr_busy   (clr_busy),
      .scan_pause (scan_pause),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rd_addr    (rd_addr),
      .rd_q       (rd_q),
      .scan_addr  (scan_addr),
      .scan_data  (scan_data),
      .scan_valid (scan_valid)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: write port plus registered read address (old data on collision).
   always @(posedge clk) begin
      if (tb_init) begin
         for (int k = 0; k < 32; k++) mem[k] <= 3'(k % 8);
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_q <= mem[rd_addr];
   end

   // Drive inputs, then advance one clock and settle just after the edge.
   task automatic applyStimulus(input logic req, input logic [4:0] addr,
                                input logic [2:0] data, input logic clr,
                                input logic pause);
      usr_req    = req;
      usr_addr   = addr;
      usr_data   = data;
      clr_start  = clr;
      scan_pause = pause;
      @(posedge clk);
      #1;
   endtask

   // Compare one observed value against its expected value.
   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   // One-cycle synchronous reset pulse.
   task automatic doReset(input logic init_mem);
      reset   = 1'b1;
      tb_init = init_mem;
      applyStimulus(1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
      reset   = 1'b0;
      tb_init = 1'b0;
   endtask

   // Main test sequence.
   initial begin
      int exp_addr;
      int polls;
      checks     = 0;
      failures   = 0;
      reset      = 1'b1;
      tb_init    = 1'b0;
      usr_req    = 1'b0;
      usr_addr   = '0;
      usr_data   = '0;
      clr_start  = 1'b0;
      scan_pause = 1'b0;

      //                req  addr   data  clr   en   addr   data  gnt   busy
      vecs[0] = '{1'b1, 5'd5,  3'd3, 1'b0, 1'b1, 5'd5,  3'd3, 1'b1, 1'b0};
      vecs[1] = '{1'b1, 5'd5,  3'd3, 1'b0, 1'b0, 5'd0,  3'd0, 1'b0, 1'b0};
      vecs[2] = '{1'b0, 5'd0,  3'd0, 1'b0, 1'b0, 5'd0,  3'd0, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 5'd0,  3'd0, 1'b0, 1'b0, 5'd0,  3'd0, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 5'd17, 3'd5, 1'b0, 1'b1, 5'd17, 3'd5, 1'b1, 1'b0};
      vecs[5] = '{1'b1, 5'd17, 3'd5, 1'b0, 1'b0, 5'd0,  3'd0, 1'b0, 1'b0};
      vecs[6] = '{1'b1, 5'd31, 3'd7, 1'b0, 1'b1, 5'd31, 3'd7, 1'b1, 1'b0};
      vecs[7] = '{1'b0, 5'd0,  3'd0, 1'b0, 1'b0, 5'd0,  3'd0, 1'b0, 1'b0};
      vecs[8] = '{1'b1, 5'd0,  3'd2, 1'b0, 1'b1, 5'd0,  3'd2, 1'b1, 1'b0};
      vecs[9] = '{1'b0, 5'd0,  3'd0, 1'b0, 1'b0, 5'd0,  3'd0, 1'b0, 1'b0};

      // Scanner: preload RAM k=k%8, scan across the 31->0 wrap.
      doReset(1'b1);
      for (int n = 0; n < 136; n++) begin
         exp_addr = (n / 4) % 32;
         checkOutput("scan_addr", int'(scan_addr), exp_addr);
         checkOutput("scan_valid", int'(scan_valid), ((n % 4) >= 2) ? 1 : 0);
         if ((n % 4) >= 2) checkOutput("scan_data", int'(scan_data), exp_addr % 8);
         applyStimulus(1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
      end
      // Cycle 136 sits at address 2 with tick 0; pause must hold it there.
      for (int n = 0; n < 8; n++) begin
         applyStimulus(1'b0, 5'd0, 3'd0, 1'b0, 1'b1);
         checkOutput("pause_addr", int'(scan_addr), 2);
      end
      checkOutput("pause_valid", int'(scan_valid), 1);
      checkOutput("pause_data", int'(scan_data), 2);

      // Write hit on the paused scan word.
      polls = 0;
      while (scan_addr != 5'd5 && polls < 400) begin
         applyStimulus(1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
         polls++;
      end
      checkOutput("reach_addr5_timeout", (polls < 400) ? 1 : 0, 1);
      for (int n = 0; n < 4; n++) applyStimulus(1'b0, 5'd0, 3'd0, 1'b0, 1'b1);
      checkOutput("hit_pre_addr", int'(scan_addr), 5);
      checkOutput("hit_pre_valid", int'(scan_valid), 1);
      checkOutput("hit_pre_data", int'(scan_data), 5);
      applyStimulus(1'b1, 5'd5, 3'd6, 1'b0, 1'b1);
      checkOutput("hit_wr_en", int'(wr_en), 1);
      checkOutput("hit_w0_valid", int'(scan_valid), 1);
      applyStimulus(1'b1, 5'd5, 3'd6, 1'b0, 1'b1);
      checkOutput("hit_w1_valid", int'(scan_valid), 0);
      applyStimulus(1'b0, 5'd0, 3'd0, 1'b0, 1'b1);
      checkOutput("hit_w2_valid", int'(scan_valid), 0);
      applyStimulus(1'b0, 5'd0, 3'd0, 1'b0, 1'b1);
      checkOutput("hit_w3_valid", int'(scan_valid), 1);
      checkOutput("hit_w3_data", int'(scan_data), 6);
      checkOutput("hit_w3_addr", int'(scan_addr), 5);

      // Reset values, then the user handshake table.
      doReset(1'b0);
      checkOutput("rst_wr_en", int'(wr_en), 0);
      checkOutput("rst_wr_addr", int'(wr_addr), 0);
      checkOutput("rst_wr_data", int'(wr_data), 0);
      checkOutput("rst_usr_gnt", int'(usr_gnt), 0);
      checkOutput("rst_clr_busy", int'(clr_busy), 0);
      checkOutput("rst_scan_addr", int'(scan_addr), 0);
      checkOutput("rst_scan_valid", int'(scan_valid), 0);
      checkOutput("rst_scan_data", int'(scan_data), 0);
      for (int v = 0; v < 10; v++) begin
         applyStimulus(vecs[v].req, vecs[v].addr, vecs[v].data, vecs[v].clr, 1'b1);
         checkOutput($sformatf("vec%0d_wr_en", v), int'(wr_en), int'(vecs[v].exp_en));
         checkOutput($sformatf("vec%0d_gnt", v), int'(usr_gnt), int'(vecs[v].exp_gnt));
         checkOutput($sformatf("vec%0d_busy", v), int'(clr_busy), int'(vecs[v].exp_busy));
         if (vecs[v].exp_en) begin
            checkOutput($sformatf("vec%0d_wr_addr", v), int'(wr_addr), int'(vecs[v].exp_addr));
            checkOutput($sformatf("vec%0d_wr_data", v), int'(wr_data), int'(vecs[v].exp_data));
         end
      end

      // Uncontended clear, with an ignored restart pulse mid-way.
      doReset(1'b0);
      applyStimulus(1'b0, 5'd0, 3'd0, 1'b1, 1'b1);
      checkOutput("clr_start_busy", int'(clr_busy), 1);
      checkOutput("clr_start_wr_en", int'(wr_en), 0);
      for (int i = 0; i < 32; i++) begin
         applyStimulus(1'b0, 5'd0, 3'd0, (i == 10) ? 1'b1 : 1'b0, 1'b1);
         checkOutput($sformatf("clr%0d_wr_en", i), int'(wr_en), 1);
         checkOutput($sformatf("clr%0d_wr_addr", i), int'(wr_addr), i);
         checkOutput($sformatf("clr%0d_wr_data", i), int'(wr_data), 0);
         checkOutput($sformatf("clr%0d_busy", i), int'(clr_busy), (i < 31) ? 1 : 0);
      end
      applyStimulus(1'b0, 5'd0, 3'd0, 1'b0, 1'b1);
      checkOutput("clr_done_wr_en", int'(wr_en), 0);
      checkOutput("clr_done_busy", int'(clr_busy), 0);

      // Clear contended by a continuously requesting user.
      doReset(1'b0);
      applyStimulus(1'b0, 5'd0, 3'd0, 1'b1, 1'b1);
      for (int j = 0; j < 65; j++) begin
         applyStimulus(1'b1, 5'd9, 3'd7, 1'b0, 1'b1);
         checkOutput($sformatf("mix%0d_wr_en", j), int'(wr_en), 1);
         checkOutput($sformatf("mix%0d_busy", j), int'(clr_busy), (j < 63) ? 1 : 0);
         if ((j % 2) == 0) begin
            checkOutput($sformatf("mix%0d_gnt", j), int'(usr_gnt), 1);
            checkOutput($sformatf("mix%0d_wr_addr", j), int'(wr_addr), 9);
            checkOutput($sformatf("mix%0d_wr_data", j), int'(wr_data), 7);
         end else begin
            checkOutput($sformatf("mix%0d_gnt", j), int'(usr_gnt), 0);
            checkOutput($sformatf("mix%0d_wr_addr", j), int'(wr_addr), (j - 1) / 2);
            checkOutput($sformatf("mix%0d_wr_data", j), int'(wr_data), 0);
         end
      end
      applyStimulus(1'b0, 5'd0, 3'd0, 1'b0, 1'b1);
      checkOutput("mix_end_wr_en", int'(wr_en), 0);

      // Reset in the middle of a clear, then a fresh clear from address 0.
      doReset(1'b0);
      applyStimulus(1'b0, 5'd0, 3'd0, 1'b1, 1'b1);
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 5'd0, 3'd0, 1'b0, 1'b1);
      checkOutput("abort_pre_addr", int'(wr_addr), 9);
      checkOutput("abort_pre_busy", int'(clr_busy), 1);
      reset = 1'b1;
      applyStimulus(1'b0, 5'd0, 3'd0, 1'b0, 1'b1);
      reset = 1'b0;
      checkOutput("abort_busy", int'(clr_busy), 0);
      checkOutput("abort_wr_en", int'(wr_en), 0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 5'd0, 3'd0, 1'b0, 1'b1);
         checkOutput($sformatf("abort_idle%0d_wr_en", i), int'(wr_en), 0);
         checkOutput($sformatf("abort_idle%0d_busy", i), int'(clr_busy), 0);
      end
      applyStimulus(1'b0, 5'd0, 3'd0, 1'b1, 1'b1);
      checkOutput("restart_busy", int'(clr_busy), 1);
      applyStimulus(1'b0, 5'd0, 3'd0, 1'b0, 1'b1);
      checkOutput("restart_wr_en", int'(wr_en), 1);
      checkOutput("restart_wr_addr", int'(wr_addr), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
